// File: rtl/iob_eth_rx_filt_pkg.sv
// Shared constants and state encoding for the Ethernet receive filter.
package iob_eth_rx_filt_pkg;

   // Last byte of the preamble (start-of-frame delimiter)
   localparam logic [7:0]  SFD_BYTE    = 8'hD5;
   // CRC register value after a frame with a correct FCS has been fed through
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
   localparam logic [47:0] BCAST_ADDR  = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_DROP    = 3'd3,
      S_DONE    = 3'd4
   } rx_state_t;

endpackage

// File: rtl/iob_eth_crc.sv
// Byte-wide Ethernet CRC-32 engine. The register runs in reflected form
// (LSB-first, polynomial 0xEDB88320, preset all ones); crc_out presents it
// bit-reversed, so a frame with a good FCS leaves crc_out at 0xC704DD7B.
module iob_eth_crc (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  data_in,
   input  logic        data_en,
   output logic [31:0] crc_out
);

   logic [31:0] crc_q;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   // CRC register: preset on start, advanced by one byte per data_en
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses <= so every register samples pre-edge values;
      // = here would let later statements see already-updated state.
      if (rst)
         crc_q <= 32'hFFFF_FFFF;
      else if (start)
         crc_q <= 32'hFFFF_FFFF;
      else if (data_en)
         crc_q <= crc_byte(crc_q, data_in);
   end

   assign crc_out = {<<{crc_q}};

endmodule

// File: rtl/iob_eth_rx_filt.sv
// MII receive front end: assembles nibbles into bytes, filters on the
// destination address and frame length, checks the FCS and writes accepted
// frames into a byte buffer, holding one ready frame until acknowledged.
module iob_eth_rx_filt
   import iob_eth_rx_filt_pkg::*;
#(
   parameter int          BUF_ADDR_W   = 11,
   parameter logic [47:0] MAC_ADDR     = 48'h0123456789AB,
   parameter int          MAX_FRAME    = 1518,
   parameter int          MIN_FRAME    = 64,
   parameter int          ACCEPT_BCAST = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_DV,
   input  logic [3:0]            RX_DATA,
   input  logic                  promisc,
   input  logic                  rcv_ack,
   output logic [BUF_ADDR_W-1:0] addr,
   output logic [7:0]            data,
   output logic                  wr,
   output logic                  frame_rdy,
   output logic [BUF_ADDR_W:0]   frame_len,
   output logic                  crc_err,
   output logic [15:0]           drop_cnt
);

   localparam logic [BUF_ADDR_W:0] MAX_CNT  = (BUF_ADDR_W+1)'(MAX_FRAME);
   localparam logic [BUF_ADDR_W:0] MIN_CNT  = (BUF_ADDR_W+1)'(MIN_FRAME);
   localparam logic [BUF_ADDR_W:0] LAST_HDR = (BUF_ADDR_W+1)'(5);

   rx_state_t           state, state_nxt;
   logic [3:0]          nib_q;      // previous nibble (SFD hunt / low half of byte)
   logic                phase;      // 1 when the next nibble completes a byte
   logic                armed;      // RX_DV seen low since reset: safe to hunt SFD
   logic                skip;       // frame arriving in DONE already counted as dropped
   logic [BUF_ADDR_W:0] byte_cnt;
   logic [39:0]         dst_q;      // first five destination bytes

   logic [7:0]          byte_val;
   logic [47:0]         dst_full;
   logic                sfd_hit, dst_ok;
   logic                hdr_start, do_write, cnt_drop, latch_frame, skip_set;
   logic [31:0]         crc_out;

   iob_eth_crc u_crc (
      .clk     (clk),
      .rst     (rst),
      .start   (state == S_IDLE),
      .data_in (byte_val),
      .data_en (do_write),
      .crc_out (crc_out)
   );

   // Next-state and per-cycle action decode
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_nxt   = state;
      hdr_start   = 1'b0;
      do_write    = 1'b0;
      cnt_drop    = 1'b0;
      latch_frame = 1'b0;
      skip_set    = 1'b0;
      byte_val    = {RX_DATA, nib_q};
      dst_full    = {dst_q, byte_val};
      sfd_hit     = RX_DV && armed && (byte_val == SFD_BYTE);
      dst_ok      = promisc || (dst_full == MAC_ADDR) ||
                    ((ACCEPT_BCAST != 0) && (dst_full == BCAST_ADDR));

      case (state)
         S_IDLE: begin
            if (sfd_hit) begin
               state_nxt = S_HDR;
               hdr_start = 1'b1;
            end
         end
         S_HDR, S_PAYLOAD: begin
            if (!RX_DV) begin
               // End of frame; any trailing odd nibble is simply not used
               if (state == S_HDR || byte_cnt < MIN_CNT) begin
                  cnt_drop  = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  latch_frame = 1'b1;
                  state_nxt   = S_DONE;
               end
            end else if (phase) begin
               if (byte_cnt == MAX_CNT) begin
                  cnt_drop  = 1'b1;
                  state_nxt = S_DROP;
               end else begin
                  do_write = 1'b1;
                  if (state == S_HDR && byte_cnt == LAST_HDR) begin
                     if (dst_ok) begin
                        state_nxt = S_PAYLOAD;
                     end else begin
                        cnt_drop  = 1'b1;
                        state_nxt = S_DROP;
                     end
                  end
               end
            end
         end
         S_DROP: begin
            if (!RX_DV) state_nxt = S_IDLE;
         end
         S_DONE: begin
            // A frame whose SFD passes while the buffer is full is lost
            if (sfd_hit && !skip) begin
               cnt_drop = 1'b1;
               skip_set = 1'b1;
            end
            if (rcv_ack)
               state_nxt = ((skip && RX_DV) || sfd_hit) ? S_DROP : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, byte assembly, buffer write port and frame status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         nib_q     <= 4'h0;
         phase     <= 1'b0;
         armed     <= 1'b0;
         skip      <= 1'b0;
         byte_cnt  <= '0;
         dst_q     <= '0;
         addr      <= '0;
         data      <= 8'h00;
         wr        <= 1'b0;
         frame_rdy <= 1'b0;
         frame_len <= '0;
         crc_err   <= 1'b0;
         drop_cnt  <= 16'h0000;
      end else begin
         state <= state_nxt;
         wr    <= do_write;

         if (RX_DV) nib_q <= RX_DATA;
         else       armed <= 1'b1;

         if (!RX_DV)        skip <= 1'b0;
         else if (skip_set) skip <= 1'b1;

         if (hdr_start)
            phase <= 1'b0;
         else if (RX_DV && (state == S_HDR || state == S_PAYLOAD))
            phase <= ~phase;

         if (hdr_start)     addr <= '0;
         else if (wr)       addr <= addr + 1'b1;

         if (hdr_start)     byte_cnt <= '0;
         else if (do_write) byte_cnt <= byte_cnt + 1'b1;

         if (do_write) begin
            data  <= byte_val;
            dst_q <= {dst_q[31:0], byte_val};
         end

         if (latch_frame) begin
            frame_len <= byte_cnt;
            crc_err   <= (crc_out != CRC_RESIDUE);
            frame_rdy <= 1'b1;
         end else if (state == S_DONE && rcv_ack) begin
            frame_rdy <= 1'b0;
         end

         if (cnt_drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_iob_eth_rx_filt.sv
// Directed self-checking bench for iob_eth_rx_filt.
module tb_iob_eth_rx_filt;

   localparam logic [47:0] MAC = 48'h0123456789AB;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RX_DV = 1'b0;
   logic [3:0]  RX_DATA = 4'h0;
   logic        promisc = 1'b0;
   logic        rcv_ack = 1'b0;
   logic [10:0] addr;
   logic [7:0]  data;
   logic        wr;
   logic        frame_rdy;
   logic [11:0] frame_len;
   logic        crc_err;
   logic [15:0] drop_cnt;

   int vectors = 0;
   int miscompares = 0;
   int exp_drop = 0;
   int wr_cnt = 0;
   logic [10:0] wr_addr_log [0:2047];
   logic [7:0]  wr_data_log [0:2047];
   logic [7:0]  tx [0:1599];

   iob_eth_rx_filt dut (
      .clk       (clk),
      .rst       (rst),
      .RX_DV     (RX_DV),
      .RX_DATA   (RX_DATA),
      .promisc   (promisc),
      .rcv_ack   (rcv_ack),
      .addr      (addr),
      .data      (data),
      .wr        (wr),
      .frame_rdy (frame_rdy),
      .frame_len (frame_len),
      .crc_err   (crc_err),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // Record every buffer write, sampled on the falling edge
   always @(negedge clk) begin
      if (wr) begin
         wr_addr_log[wr_cnt % 2048] = addr;
         wr_data_log[wr_cnt % 2048] = data;
         wr_cnt = wr_cnt + 1;
      end
   end

   // Global time limit
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   // Fill tx[0..len-1]: dst, src, type, payload, then a correct FCS
   task automatic build_frame(input logic [47:0] dst, input int len);
      logic [31:0] c;
      for (int i = 0; i < 6; i++) tx[i] = dst[47-8*i -: 8];
      for (int i = 6; i < 12; i++) tx[i] = 8'(8'h10 + i);
      tx[12] = 8'h08;
      tx[13] = 8'h00;
      for (int i = 14; i < len - 4; i++) tx[i] = 8'(i * 7 + 3);
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < len - 4; i++) c = crc_upd(c, tx[i]);
      c = ~c;
      tx[len-4] = c[7:0];
      tx[len-3] = c[15:8];
      tx[len-2] = c[23:16];
      tx[len-1] = c[31:24];
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      RX_DV = 1'b1;
      RX_DATA = b[3:0];
      @(posedge clk); #1;
      RX_DATA = b[7:4];
   endtask

   task automatic send_preamble();
      for (int i = 0; i < 7; i++) send_byte(8'h55);
      send_byte(8'hD5);
   endtask

   task automatic end_frame();
      @(posedge clk); #1;
      RX_DV = 1'b0;
      RX_DATA = 4'h0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int len);
      send_preamble();
      for (int i = 0; i < len; i++) send_byte(tx[i]);
      end_frame();
   endtask

   task automatic do_ack();
      @(posedge clk); #1;
      rcv_ack = 1'b1;
      @(posedge clk); #1;
      rcv_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({addr, data, wr, frame_rdy, frame_len, crc_err, drop_cnt} !== '0) begin
         $display("FAIL reset_outputs: got addr=%0d data=%h wr=%b rdy=%b len=%0d crc=%b drop=%0d, want all 0",
                  addr, data, wr, frame_rdy, frame_len, crc_err, drop_cnt);
         miscompares++;
      end
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (wr !== 1'b0 || frame_rdy !== 1'b0) begin
         $display("FAIL idle_after_reset: got wr=%b rdy=%b, want 0 0", wr, frame_rdy);
         miscompares++;
      end
   endtask

   task automatic test_good_frame();
      int base;
      build_frame(MAC, 64);
      base = wr_cnt;
      send_frame(64);
      vectors++;
      if (wr_cnt - base !== 64) begin
         $display("FAIL good_wr_count: got %0d, want 64", wr_cnt - base);
         miscompares++;
      end
      for (int i = 0; i < 64; i++) begin
         vectors++;
         if (wr_addr_log[(base+i) % 2048] !== 11'(i) || wr_data_log[(base+i) % 2048] !== tx[i]) begin
            $display("FAIL good_write[%0d]: got addr=%0d data=%h, want addr=%0d data=%h",
                     i, wr_addr_log[(base+i) % 2048], wr_data_log[(base+i) % 2048], i, tx[i]);
            miscompares++;
         end
      end
      vectors++;
      if (frame_rdy !== 1'b1 || frame_len !== 12'd64 || crc_err !== 1'b0) begin
         $display("FAIL good_status: got rdy=%b len=%0d crc=%b, want 1 64 0", frame_rdy, frame_len, crc_err);
         miscompares++;
      end
      do_ack();
      vectors++;
      if (frame_rdy !== 1'b0) begin
         $display("FAIL ack_clears_rdy: got %b, want 0", frame_rdy);
         miscompares++;
      end
   endtask

   task automatic test_crc_error();
      build_frame(MAC, 64);
      tx[20] = tx[20] ^ 8'h04;
      send_frame(64);
      vectors++;
      if (frame_rdy !== 1'b1 || crc_err !== 1'b1 || frame_len !== 12'd64) begin
         $display("FAIL crc_bad_frame: got rdy=%b crc=%b len=%0d, want 1 1 64", frame_rdy, crc_err, frame_len);
         miscompares++;
      end
      do_ack();
   endtask

   task automatic test_dst_filter();
      int base;
      // Foreign unicast, promisc off: dropped after the address
      build_frame(48'h0200_0000_0001, 64);
      base = wr_cnt;
      send_frame(64);
      exp_drop++;
      vectors++;
      if (wr_cnt - base !== 6 || drop_cnt !== 16'(exp_drop) || frame_rdy !== 1'b0) begin
         $display("FAIL dst_reject: got writes=%0d drop=%0d rdy=%b, want 6 %0d 0",
                  wr_cnt - base, drop_cnt, frame_rdy, exp_drop);
         miscompares++;
      end
      // Same frame, promisc on: accepted
      promisc = 1'b1;
      base = wr_cnt;
      send_frame(64);
      vectors++;
      if (wr_cnt - base !== 64 || frame_rdy !== 1'b1 || crc_err !== 1'b0 || drop_cnt !== 16'(exp_drop)) begin
         $display("FAIL dst_promisc: got writes=%0d rdy=%b crc=%b drop=%0d, want 64 1 0 %0d",
                  wr_cnt - base, frame_rdy, crc_err, drop_cnt, exp_drop);
         miscompares++;
      end
      do_ack();
      promisc = 1'b0;
      // Broadcast accepted
      build_frame(48'hFFFF_FFFF_FFFF, 68);
      send_frame(68);
      vectors++;
      if (frame_rdy !== 1'b1 || frame_len !== 12'd68 || crc_err !== 1'b0) begin
         $display("FAIL dst_bcast: got rdy=%b len=%0d crc=%b, want 1 68 0", frame_rdy, frame_len, crc_err);
         miscompares++;
      end
      do_ack();
   endtask

   task automatic test_length();
      int base;
      build_frame(MAC, 40);
      send_frame(40);
      exp_drop++;
      vectors++;
      if (drop_cnt !== 16'(exp_drop) || frame_rdy !== 1'b0) begin
         $display("FAIL len_short: got drop=%0d rdy=%b, want %0d 0", drop_cnt, frame_rdy, exp_drop);
         miscompares++;
      end
      build_frame(MAC, 1600);
      base = wr_cnt;
      send_frame(1600);
      exp_drop++;
      vectors++;
      if (wr_cnt - base !== 1518 || wr_addr_log[(base+1517) % 2048] !== 11'd1517) begin
         $display("FAIL len_long_writes: got writes=%0d last_addr=%0d, want 1518 1517",
                  wr_cnt - base, wr_addr_log[(base+1517) % 2048]);
         miscompares++;
      end
      vectors++;
      if (drop_cnt !== 16'(exp_drop) || frame_rdy !== 1'b0) begin
         $display("FAIL len_long_drop: got drop=%0d rdy=%b, want %0d 0", drop_cnt, frame_rdy, exp_drop);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      int base;
      build_frame(MAC, 64);
      send_frame(64);
      vectors++;
      if (frame_rdy !== 1'b1 || frame_len !== 12'd64) begin
         $display("FAIL b2b_first: got rdy=%b len=%0d, want 1 64", frame_rdy, frame_len);
         miscompares++;
      end
      build_frame(MAC, 80);
      base = wr_cnt;
      send_frame(80);
      exp_drop++;
      vectors++;
      if (wr_cnt - base !== 0 || drop_cnt !== 16'(exp_drop)) begin
         $display("FAIL b2b_ignored: got writes=%0d drop=%0d, want 0 %0d", wr_cnt - base, drop_cnt, exp_drop);
         miscompares++;
      end
      vectors++;
      if (frame_rdy !== 1'b1 || frame_len !== 12'd64 || crc_err !== 1'b0) begin
         $display("FAIL b2b_held: got rdy=%b len=%0d crc=%b, want 1 64 0", frame_rdy, frame_len, crc_err);
         miscompares++;
      end
      do_ack();
      build_frame(MAC, 70);
      send_frame(70);
      vectors++;
      if (frame_rdy !== 1'b1 || frame_len !== 12'd70 || crc_err !== 1'b0 || drop_cnt !== 16'(exp_drop)) begin
         $display("FAIL b2b_third: got rdy=%b len=%0d crc=%b drop=%0d, want 1 70 0 %0d",
                  frame_rdy, frame_len, crc_err, drop_cnt, exp_drop);
         miscompares++;
      end
      do_ack();
   endtask

   task automatic test_rst_midframe();
      int base;
      build_frame(MAC, 64);
      base = wr_cnt;
      send_preamble();
      for (int i = 0; i < 64; i++) begin
         if (i == 30) rst = 1'b1;
         send_byte(tx[i]);
         if (i == 31) begin
            vectors++;
            if ({addr, data, wr, frame_rdy, frame_len, crc_err, drop_cnt} !== '0) begin
               $display("FAIL rst_mid_outputs: got addr=%0d data=%h wr=%b rdy=%b len=%0d crc=%b drop=%0d, want all 0",
                        addr, data, wr, frame_rdy, frame_len, crc_err, drop_cnt);
               miscompares++;
            end
            rst = 1'b0;
            base = wr_cnt;
         end
      end
      end_frame();
      exp_drop = 0;
      vectors++;
      if (wr_cnt - base !== 0 || drop_cnt !== 16'(exp_drop) || frame_rdy !== 1'b0) begin
         $display("FAIL rst_mid_abandon: got writes=%0d drop=%0d rdy=%b, want 0 0 0",
                  wr_cnt - base, drop_cnt, frame_rdy);
         miscompares++;
      end
      build_frame(MAC, 64);
      base = wr_cnt;
      send_frame(64);
      vectors++;
      if (wr_cnt - base !== 64 || frame_rdy !== 1'b1 || frame_len !== 12'd64 || crc_err !== 1'b0) begin
         $display("FAIL rst_mid_next: got writes=%0d rdy=%b len=%0d crc=%b, want 64 1 64 0",
                  wr_cnt - base, frame_rdy, frame_len, crc_err);
         miscompares++;
      end
      do_ack();
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_crc_error();
      test_dst_filter();
      test_length();
      test_back_to_back();
      test_rst_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/iob_eth_rx_filt.md
IOB_ETH_RX_FILT -- requirements
Module: iob_eth_rx_filt

Interface
REQ-001 Parameter BUF_ADDR_W, default 11: width of the frame-buffer byte address.
REQ-002 Parameter MAC_ADDR, default 48'h0123456789AB: station address accepted by the destination filter.
REQ-003 Parameter MAX_FRAME, default 1518: largest accepted frame in bytes, destination MAC through FCS, and never above 2**BUF_ADDR_W.
REQ-004 Parameter MIN_FRAME, default 64: smallest accepted frame in bytes.
REQ-005 Parameter ACCEPT_BCAST, default 1: when 1, destination FF:FF:FF:FF:FF:FF is accepted.
REQ-006 Port clk  in  1  receive clock; all logic is on its rising edge.
REQ-007 Port rst  in  1  asynchronous, active-high reset.
REQ-008 Port RX_DV  in  1  MII receive data valid.
REQ-009 Port RX_DATA  in  4  MII receive nibble, low nibble of each byte first.
REQ-010 Port promisc  in  1  disables destination filtering while high.
REQ-011 Port rcv_ack  in  1  single-cycle pulse: consumer has read the buffered frame.
REQ-012 Port addr  out  BUF_ADDR_W  buffer write address.
REQ-013 Port data  out  8  buffer write byte.
REQ-014 Port wr  out  1  buffer write strobe.
REQ-015 Port frame_rdy  out  1  a complete accepted frame is in the buffer.
REQ-016 Port frame_len  out  BUF_ADDR_W+1  byte count of the ready frame, FCS included.
REQ-017 Port crc_err  out  1  the ready frame failed the FCS check.
REQ-018 Port drop_cnt  out  16  saturating count of discarded frames.

Function
REQ-019 States SHALL be IDLE, HDR, PAYLOAD, DROP and DONE.
REQ-020 IDLE SHALL shift nibbles while RX_DV is high and go to HDR when the assembled byte {RX_DATA, previous nibble} equals 8'hD5; addr and the byte counter clear on entry to HDR.
REQ-021 In HDR and PAYLOAD, every second valid nibble SHALL complete a byte; wr pulses exactly one cycle later with data = that byte, and addr increments by 1 after each write.
REQ-022 After the 6th header byte, HDR SHALL go to PAYLOAD if promisc is high, or the address equals MAC_ADDR, or (ACCEPT_BCAST and the address is broadcast); otherwise it SHALL go to DROP.
REQ-023 PAYLOAD SHALL end when RX_DV falls; a trailing odd nibble is discarded.
REQ-024 At end of frame, if the byte count is below MIN_FRAME the frame SHALL be discarded, drop_cnt increments and the state returns to IDLE.
REQ-025 Otherwise, frame_len SHALL latch the byte count, crc_err SHALL latch (CRC residue != 32'hC704DD7B), and the state goes to DONE with frame_rdy high on the following cycle.
REQ-026 When a write would exceed MAX_FRAME bytes, that write SHALL be suppressed and the state goes to DROP.
REQ-027 DROP SHALL increment drop_cnt once on entry and return to IDLE when RX_DV is low.
REQ-028 DONE SHALL hold frame_rdy, frame_len and crc_err stable, with wr held low.
REQ-029 A frame whose RX_DV rises while in DONE SHALL be ignored in full and counted once in drop_cnt.
REQ-030 rcv_ack in DONE SHALL clear frame_rdy and enter IDLE on the next cycle; an ack in the same cycle as an RX_DV rise lets that frame be received only if its SFD has not yet passed.
REQ-031 rcv_ack outside DONE SHALL be ignored.
REQ-032 drop_cnt SHALL saturate at 16'hFFFF.
REQ-033 The CRC engine SHALL be cleared in IDLE and SHALL be fed every written byte, header and FCS included.

Reset
REQ-034 On rst, the state SHALL go to IDLE and addr, data, wr, frame_rdy, frame_len, crc_err, drop_cnt and the nibble shifter SHALL clear to 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame without incrementing drop_cnt; after release, reception resumes only at the next SFD.

Structure
REQ-036 The shared package SHALL hold the preamble/SFD constant 8'hD5, the CRC residue 32'hC704DD7B, the broadcast address and the state encodings.
REQ-037 CRC SHALL be computed by one instance of the existing iob_eth_crc sub-module (start, data_in, data_en, crc_out).

Verification
REQ-038 Test: 7x55 preamble, D5, then a 64-byte frame to MAC_ADDR with a valid FCS -> 64 wr pulses at addr 0..63, frame_rdy=1, frame_len=64, crc_err=0.
REQ-039 Test: same frame with one payload bit flipped -> frame_rdy=1, crc_err=1.
REQ-040 Test: frame to 02:00:00:00:00:01 with promisc=0 -> exactly 6 writes, drop_cnt=1, no frame_rdy; repeat with promisc=1 -> frame accepted.
REQ-041 Test: 40-byte frame -> drop_cnt increments and frame_rdy stays 0; 1600-byte frame -> writes stop at addr 1517 and drop_cnt increments.
REQ-042 Test: second valid frame sent while frame_rdy=1 -> no wr pulses and drop_cnt+1; then rcv_ack, third frame -> accepted.
REQ-043 Test: rst asserted at byte 30 of a frame -> all outputs 0, drop_cnt unchanged, next frame received normally.
